// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART Tx parity generator and Rx frame checker.
//   uart_state_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN/ODD : values of the parity_type control input
//   maj3         : 2-of-3 majority vote used by the oversampler
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling engine for the UART receiver. Counts clocks within a
// bit period, captures three samples around the bit centre and votes on them.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        hold the edge counter at 0 (receiver idle)
//   rx_i           synchronized serial line
//   presc_i        clocks per bit (latched by the caller for the frame)
//   bit_done_o     strobe on the last clock of a bit period
//   bit_val_o      majority-voted bit value, valid while bit_done_o is high
// ----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               rx_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               bit_done_o,
    output logic               bit_val_o
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic               s0_q, s0_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;

    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] mid_lo;
    logic [PRESC_W-1:0] mid_hi;
    logic [PRESC_W-1:0] last;
    logic               at_last;
    logic               s2_now;

    assign half    = presc_i >> 1;
    assign mid_lo  = half - ONE;
    assign mid_hi  = half + ONE;
    assign last    = presc_i - ONE;
    assign at_last = (edge_cnt_q == last);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        if (clear_i) begin
            edge_cnt_d = '0;
        end else begin
            // Wrap on P-1 for any prescale value so an odd setting never stalls.
            edge_cnt_d = at_last ? '0 : edge_cnt_q + ONE;
            if (edge_cnt_q == mid_lo) s0_d = rx_i;
            if (edge_cnt_q == half)   s1_d = rx_i;
            if (edge_cnt_q == mid_hi) s2_d = rx_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    // With a small prescale the third sample point can coincide with the
    // last clock of the bit, so take it straight from the line in that case.
    assign s2_now     = (edge_cnt_q == mid_hi) ? rx_i : s2_q;
    assign bit_done_o = !clear_i && at_last;
    assign bit_val_o  = maj3(s0_q, s1_q, s2_now);

endmodule : uart_rx_sampler

// File: rtl/uart_rx_frame_checker.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_checker
// UART receiver: deserializes start, DATA_WIDTH data bits (LSB first), an
// optional parity bit and one stop bit, checks parity and stop, and delivers
// each error-free byte with a one-cycle valid pulse.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   rx_in          serial line (idle high, asynchronous to clk)
//   prescale       clocks per bit (8/16/32), latched at frame start
//   parity_en      frame carries a parity bit, latched at frame start
//   parity_type    0 even / 1 odd, latched at frame start
//   data_out       last good byte, held until the next good frame
//   data_valid     one-cycle pulse when data_out is updated
//   parity_error   one-cycle pulse at end of a mismatching parity bit
//   stop_error     one-cycle pulse at end of a stop bit sampled low
//   busy           high while a frame is being received
// ----------------------------------------------------------------------------
module uart_rx_frame_checker
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two-flop synchronizer, reset to the idle line level.
    logic sync1_q, sync2_q;
    logic rx_s;

    uart_state_e             state_q, state_d;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic                    pen_q, pen_d;
    logic                    ptype_q, ptype_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    stop_error_q, stop_error_d;

    logic bit_done;
    logic bit_val;
    logic par_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (state_q == IDLE),
        .rx_i       (rx_s),
        .presc_i    (presc_q),
        .bit_done_o (bit_done),
        .bit_val_o  (bit_val)
    );

    assign par_exp = (ptype_q == PAR_ODD) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        pen_d          = pen_q;
        ptype_d        = ptype_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        ferr_d         = ferr_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    presc_d   = prescale;
                    pen_d     = parity_en;
                    ptype_d   = parity_type;
                    bit_cnt_d = '0;
                    ferr_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    // A start bit that votes high was a glitch: drop it silently.
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = pen_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    if (bit_val != par_exp) begin
                        parity_error_d = 1'b1;
                        ferr_d         = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!bit_val) begin
                        stop_error_d = 1'b1;
                    end else if (!ferr_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            pen_q          <= 1'b0;
            ptype_q        <= PAR_EVEN;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            ferr_q         <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            pen_q          <= pen_d;
            ptype_q        <= ptype_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            ferr_q         <= ferr_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign busy         = (state_q != IDLE);

endmodule : uart_rx_frame_checker
